// File: rtl/pixel_stream_source_if.sv
// Bundles the frame-buffer RAM read port and the outgoing pixel stream of pixel_stream_source.
// The master side is the pixel source; the slave side is the RAM plus downstream sink.
interface pixel_stream_source_if #(
  parameter int ADDR_W = 18
);
  logic              o_mem_en;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [7:0]        i_mem_data;
  logic              o_data_valid;
  logic [7:0]        o_data;
  logic              i_data_ready;
  logic              o_data_last;
  logic              o_data_user;

  modport master (
    output o_mem_en, o_mem_addr, o_data_valid, o_data, o_data_last, o_data_user,
    input  i_mem_data, i_data_ready
  );

  modport slave (
    input  o_mem_en, o_mem_addr, o_data_valid, o_data, o_data_last, o_data_user,
    output i_mem_data, i_data_ready
  );
endinterface

// File: rtl/pixel_stream_source.sv
// Raster-order frame-buffer reader feeding a valid/ready pixel stream, paced by line credits.
// Optional macro SRC_PERF_CNT_EN adds the o_stall_cycles backpressure counter.
module pixel_stream_source #(
  parameter int IMG_WIDTH     = 512,
  parameter int IMG_HEIGHT    = 512,
  parameter int ADDR_W        = 18,
  parameter int PRELOAD_LINES = 4
) (
  input  logic                   axi_clk,
  input  logic                   axi_reset_n,
  input  logic                   i_start,
  input  logic                   i_intr,
  pixel_stream_source_if.master  bus,
  output logic                   o_busy,
  output logic                   o_done
`ifdef SRC_PERF_CNT_EN
  ,
  output logic [31:0]            o_stall_cycles
`endif
);

  localparam int COL_W  = $clog2(IMG_WIDTH);
  localparam int LINE_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_WIDTH - 1);
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(IMG_HEIGHT - 1);
  localparam logic [3:0]        PRELOAD   = 4'(PRELOAD_LINES);

  typedef enum logic [1:0] {IDLE, LOAD, READ, DRAIN} state_t;

  state_t            state, state_next;
  logic [3:0]        credit_cnt, credit_next;
  logic [ADDR_W-1:0] addr;
  logic [COL_W-1:0]  rd_col;
  logic [LINE_W-1:0] rd_line;
  logic              rd_pend, rd_pend_last, rd_pend_user;
  logic [7:0]        fifo_data [2];
  logic [1:0]        fifo_last, fifo_user;
  logic              wr_ptr, rd_ptr;
  logic [1:0]        fifo_cnt, occupancy;
  logic              start_ok, pop, issue, consume, line_end, frame_end, drained;

  always_comb begin
    start_ok  = (state == IDLE) && i_start;
    pop       = (fifo_cnt != 2'd0) && bus.i_data_ready;
    occupancy = fifo_cnt + {1'b0, rd_pend} - {1'b0, pop};
    line_end  = (rd_col == LAST_COL);
    frame_end = line_end && (rd_line == LAST_LINE);
    drained   = (fifo_cnt == 2'd0) && !rd_pend;
  end

  // A line end with a credit on hand consumes it in place, so lines stream back to back.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    consume    = 1'b0;
    o_done     = 1'b0;
    case (state)
      IDLE:  if (i_start) state_next = LOAD;
      LOAD:  if (credit_cnt != 4'd0) begin
               consume    = 1'b1;
               state_next = READ;
             end
      READ:  if (occupancy < 2'd2) begin
               issue = 1'b1;
               if (frame_end)                state_next = DRAIN;
               else if (line_end) begin
                 if (credit_cnt != 4'd0)     consume    = 1'b1;
                 else                        state_next = LOAD;
               end
             end
      DRAIN: if (drained) begin
               o_done     = 1'b1;
               state_next = IDLE;
             end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    credit_next = credit_cnt;
    if (start_ok)
      credit_next = PRELOAD;
    else if (state != IDLE) begin
      if (i_intr && !consume && credit_cnt != 4'hF)
        credit_next = credit_cnt + 4'd1;
      else if (!i_intr && consume)
        credit_next = credit_cnt - 4'd1;
    end
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state      <= IDLE;
      credit_cnt <= 4'd0;
    end else begin
      state      <= state_next;
      credit_cnt <= credit_next;
    end
  end

  // The address stops on the final pixel so it never leaves the frame range.
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      addr         <= '0;
      rd_col       <= '0;
      rd_line      <= '0;
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
      rd_pend_user <= 1'b0;
    end else begin
      rd_pend <= issue;
      if (start_ok) begin
        addr    <= '0;
        rd_col  <= '0;
        rd_line <= '0;
      end else if (issue) begin
        rd_pend_last <= line_end;
        rd_pend_user <= (rd_line == '0) && (rd_col == '0);
        if (!frame_end) addr <= addr + 1'b1;
        if (line_end) begin
          rd_col  <= '0;
          rd_line <= frame_end ? '0 : rd_line + 1'b1;
        end else begin
          rd_col <= rd_col + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      fifo_data[0] <= 8'd0;
      fifo_data[1] <= 8'd0;
      fifo_last    <= 2'b00;
      fifo_user    <= 2'b00;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      fifo_cnt     <= 2'd0;
    end else begin
      if (rd_pend) begin
        fifo_data[wr_ptr] <= bus.i_mem_data;
        fifo_last[wr_ptr] <= rd_pend_last;
        fifo_user[wr_ptr] <= rd_pend_user;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, rd_pend} - {1'b0, pop};
    end
  end

  assign o_busy           = (state != IDLE);
  assign bus.o_mem_en     = issue;
  assign bus.o_mem_addr   = addr;
  assign bus.o_data_valid = (fifo_cnt != 2'd0);
  assign bus.o_data       = fifo_data[rd_ptr];
  assign bus.o_data_last  = fifo_last[rd_ptr];
  assign bus.o_data_user  = fifo_user[rd_ptr];

`ifdef SRC_PERF_CNT_EN
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n)
      o_stall_cycles <= 32'd0;
    else if (start_ok)
      o_stall_cycles <= 32'd0;
    else if (o_busy && bus.o_data_valid && !bus.i_data_ready)
      o_stall_cycles <= o_stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_pixel_stream_source.sv
// Self-checking bench for pixel_stream_source: a 4x3 image on two instances (3 and 1 preload credits).
// Expected pixels/tags come from the raster index; credits from plain arithmetic.
module tb_pixel_stream_source;
  localparam int W = 4;
  localparam int H = 3;
  localparam int NPIX = W * H;
  localparam int PRELOAD_A = 3;

  typedef struct {
    bit          invert;
    int unsigned ready_pct;
    logic [7:0]  first_pix;
    logic [7:0]  last_pix;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0, intr = 1'b0;
  logic busy_a, done_a, busy_b, done_b;
`ifdef SRC_PERF_CNT_EN
  logic [31:0] stall_a, stall_b;
`endif

  pixel_stream_source_if #(.ADDR_W(4)) bus_a ();
  pixel_stream_source_if #(.ADDR_W(4)) bus_b ();

  pixel_stream_source #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_W(4), .PRELOAD_LINES(PRELOAD_A)) dut_a (
    .axi_clk(clk), .axi_reset_n(rst_n), .i_start(start_a), .i_intr(intr),
    .bus(bus_a), .o_busy(busy_a), .o_done(done_a)
`ifdef SRC_PERF_CNT_EN
    , .o_stall_cycles(stall_a)
`endif
  );

  pixel_stream_source #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_W(4), .PRELOAD_LINES(1)) dut_b (
    .axi_clk(clk), .axi_reset_n(rst_n), .i_start(start_b), .i_intr(intr),
    .bus(bus_b), .o_busy(busy_b), .o_done(done_b)
`ifdef SRC_PERF_CNT_EN
    , .o_stall_cycles(stall_b)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit invert_mode = 1'b0;
  bit rand_ready_en = 1'b0;
  int unsigned ready_pct = 100;
  int cyc = 0;
  logic [9:0] got_q[$];
  int xfer_cyc[$];
  int done_cyc[$];
  logic [7:0] got_b[$];
  int memen_b = 0;
  int done_b_cnt = 0;
  int max_occ = 0;
  bit stall_prev = 1'b0;
  logic [9:0] stall_val;
  vec_t vecs[4];

  function automatic logic [7:0] ramWord(input logic [3:0] a);
    logic [7:0] w;
    w = {4'b0000, a};
    return invert_mode ? ~w : w;
  endfunction

  // Synchronous RAMs with one cycle of read latency.
  always @(posedge clk) begin
    if (bus_a.o_mem_en) bus_a.i_mem_data <= ramWord(bus_a.o_mem_addr);
    if (bus_b.o_mem_en) bus_b.i_mem_data <= ramWord(bus_b.o_mem_addr);
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready_en) bus_a.i_data_ready = ($urandom_range(0, 99) < ready_pct);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Transfers, stall stability and buffer occupancy are observed mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        checkOutput("stall_hold", {21'd0, bus_a.o_data_valid, bus_a.o_data_user, bus_a.o_data_last, bus_a.o_data},
                    {21'd0, 1'b1, stall_val});
      if (bus_a.o_data_valid && bus_a.i_data_ready) begin
        got_q.push_back({bus_a.o_data_user, bus_a.o_data_last, bus_a.o_data});
        xfer_cyc.push_back(cyc);
      end
      stall_prev = bus_a.o_data_valid && !bus_a.i_data_ready;
      stall_val  = {bus_a.o_data_user, bus_a.o_data_last, bus_a.o_data};
      if (int'(dut_a.fifo_cnt) > max_occ) max_occ = int'(dut_a.fifo_cnt);
      if (done_a) done_cyc.push_back(cyc);
      if (bus_b.o_data_valid && bus_b.i_data_ready) got_b.push_back(bus_b.o_data);
      if (bus_b.o_mem_en) memen_b++;
      if (done_b) done_b_cnt++;
    end
  end

  function automatic int curCount(input int sel);
    case (sel)
      0: return got_q.size();
      1: return done_cyc.size();
      2: return got_b.size();
      default: return done_b_cnt;
    endcase
  endfunction

  task automatic waitCount(input string name, input int sel, input int n, input int budget);
    int k = 0;
    while (curCount(sel) < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkOutput(name, curCount(sel) >= n, 1);
  endtask

  task automatic clearA();
    got_q.delete();
    xfer_cyc.delete();
    done_cyc.delete();
    max_occ = 0;
  endtask

  task automatic pulseStartA();
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
  endtask

  task automatic pulseIntr();
    @(posedge clk); #1 intr = 1'b1;
    @(posedge clk); #1 intr = 1'b0;
  endtask

  task automatic checkFrame(input bit inv, input bit back_to_back);
    logic [9:0] exp;
    checkOutput("pixel_count", got_q.size(), NPIX);
    for (int i = 0; i < NPIX && i < got_q.size(); i++) begin
      exp[7:0] = inv ? 8'(255 - i) : 8'(i);
      exp[8]   = ((i % W) == W - 1);
      exp[9]   = (i == 0);
      checkOutput($sformatf("pixel_%0d", i), got_q[i], exp);
    end
    if (back_to_back && xfer_cyc.size() == NPIX)
      checkOutput("back_to_back", xfer_cyc[NPIX-1] - xfer_cyc[0], NPIX - 1);
    if (done_cyc.size() > 0 && xfer_cyc.size() == NPIX)
      checkOutput("done_timing", done_cyc[0], xfer_cyc[NPIX-1] + 1);
    checkOutput("busy_after_done", busy_a, 0);
    checkOutput("occupancy_le_2", max_occ <= 2, 1);
  endtask

  task automatic applyStimulus(input vec_t v);
    clearA();
    invert_mode = v.invert;
    ready_pct   = v.ready_pct;
    rand_ready_en = 1'b1;
    pulseStartA();
    waitCount("frame_done", 1, 1, 600);
    @(negedge clk);
    rand_ready_en = 1'b0;
    bus_a.i_data_ready = 1'b1;
    checkFrame(v.invert, v.ready_pct == 100);
    if (got_q.size() == NPIX) begin
      checkOutput("first_pix", got_q[0][7:0], v.first_pix);
      checkOutput("last_pix", got_q[NPIX-1][7:0], v.last_pix);
    end
    checkOutput("done_once", done_cyc.size(), 1);
  endtask

  initial begin
    int cred_model;
    vecs[0] = '{1'b0, 100, 8'd0,   8'd11};
    vecs[1] = '{1'b1, 50,  8'd255, 8'd244};
    vecs[2] = '{1'b0, 70,  8'd0,   8'd11};
    vecs[3] = '{1'b1, 100, 8'd255, 8'd244};

    bus_a.i_data_ready = 1'b1;
    bus_b.i_data_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy_a", busy_a, 0);
    checkOutput("rst_valid_a", bus_a.o_data_valid, 0);
    checkOutput("rst_memen_a", bus_a.o_mem_en, 0);
    checkOutput("rst_sideband_a", {bus_a.o_data_user, bus_a.o_data_last, bus_a.o_data, bus_a.o_mem_addr}, 0);
    checkOutput("rst_done_a", done_a, 0);
    checkOutput("rst_busy_b", busy_b, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);

    // Single preload credit: each further line needs its own interrupt.
    invert_mode = 1'b0;
    got_b.delete();
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    waitCount("b_line0", 2, 4, 50);
    memen_b = 0;
    repeat (10) @(negedge clk);
    checkOutput("b_starved_pixels", got_b.size(), 4);
    checkOutput("b_starved_memen", memen_b, 0);
    pulseIntr();
    waitCount("b_line1", 2, 8, 50);
    memen_b = 0;
    repeat (10) @(negedge clk);
    checkOutput("b_starved2_pixels", got_b.size(), 8);
    checkOutput("b_starved2_memen", memen_b, 0);
    pulseIntr();
    waitCount("b_done", 3, 1, 50);
    for (int i = 0; i < NPIX && i < got_b.size(); i++)
      checkOutput($sformatf("b_pixel_%0d", i), got_b[i], 8'(i));
    checkOutput("idle_intr_ignored", dut_a.credit_cnt, 0);

    // Interrupt coinciding with the frame-start credit, then saturation, plus a start mid-frame.
    clearA();
    bus_a.i_data_ready = 1'b0;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0; intr = 1'b1;
    @(posedge clk); #1 intr = 1'b0;
    cred_model = PRELOAD_A;
    repeat (3) @(negedge clk);
    checkOutput("credit_coincident", dut_a.credit_cnt, cred_model);
    for (int i = 0; i < 20; i++) begin
      pulseIntr();
      cred_model = (cred_model + 1 > 15) ? 15 : cred_model + 1;
      if (i == 10) pulseStartA();
    end
    @(negedge clk);
    checkOutput("credit_saturate", dut_a.credit_cnt, cred_model);
    @(posedge clk); #1 bus_a.i_data_ready = 1'b1;
    waitCount("sat_frame_done", 1, 1, 200);
    @(negedge clk);
    cred_model = cred_model - (H - 1);
    checkOutput("credit_after_frame", dut_a.credit_cnt, cred_model);
    checkFrame(1'b0, 1'b0);
    repeat (10) @(negedge clk);
    checkOutput("start_ignored_busy", busy_a, 0);
    checkOutput("start_ignored_done", done_cyc.size(), 1);

    // Reset in the middle of the last line, then a clean frame.
    clearA();
    pulseStartA();
    waitCount("pre_reset_pixels", 0, 10, 100);
    done_cyc.delete();
    rst_n = 1'b0;
    #1;
    checkOutput("reset_busy", busy_a, 0);
    checkOutput("reset_valid", bus_a.o_data_valid, 0);
    checkOutput("reset_memen", bus_a.o_mem_en, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("no_done_after_abort", done_cyc.size(), 0);
    applyStimulus(vecs[0]);

`ifdef SRC_PERF_CNT_EN
    clearA();
    pulseStartA();
    waitCount("perf_pixels", 0, 2, 50);
    @(posedge clk); #1 bus_a.i_data_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 bus_a.i_data_ready = 1'b1;
    waitCount("perf_done", 1, 1, 100);
    @(negedge clk);
    checkOutput("stall_cycles", stall_a, 5);
    clearA();
    pulseStartA();
    @(negedge clk);
    checkOutput("stall_cleared", stall_a, 0);
    waitCount("perf_done2", 1, 1, 100);
    @(negedge clk);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
